mem_arbiter: RTL and testbench

Two-port request/acknowledge controller that shares the 256 x 32-bit banked memory (four 64-word banks, bank selected by address[7:6]) between two requesters. Round-robin arbitration grants one access at a time. The block sequences the memory's address, write-enable and write-data inputs, and captures read data after a configurable read latency. It sits between two bus masters and the memory top level.

---
 rtl/mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin two-requester controller for the 256x32 banked memory.
// Sequences address, write-enable and write data, and captures read data after RD_LAT cycles.
module mem_arbiter #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [7:0]  addr0,
  input  logic [7:0]  addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata,
  output logic        busy,
  output logic [7:0]  mem_addr,
  output logic        mem_write,
  output logic [31:0] mem_in,
  input  logic [31:0] mem_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [2:0] LAT_CNT = RD_LAT[2:0];

  state_t      state_r, state_nxt_s;
  logic [2:0]  cnt_r, cnt_nxt_s;
  logic        last_r, last_nxt_s;
  logic        gnt_r, gnt_nxt_s;
  logic        we_r, we_nxt_s;
  logic [7:0]  addr_r, addr_nxt_s;
  logic [31:0] wdata_r, wdata_nxt_s;
  logic        write_r, write_nxt_s;
  logic        ack0_r, ack0_nxt_s;
  logic        ack1_r, ack1_nxt_s;
  logic        busy_r, busy_nxt_s;
  logic [31:0] rdata_r, rdata_nxt_s;

  logic        gnt_valid_s;
  logic        gnt_id_s;
  logic        sel_we_s;

  // Next-state and next-output logic; on a tie the requester not served last wins.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    last_nxt_s  = last_r;
    gnt_nxt_s   = gnt_r;
    we_nxt_s    = we_r;
    addr_nxt_s  = addr_r;
    wdata_nxt_s = wdata_r;
    write_nxt_s = 1'b0;
    ack0_nxt_s  = 1'b0;
    ack1_nxt_s  = 1'b0;
    busy_nxt_s  = busy_r;
    rdata_nxt_s = rdata_r;
    gnt_valid_s = 1'b0;
    gnt_id_s    = 1'b0;
    sel_we_s    = 1'b0;

    if (req0 && req1) begin
      gnt_valid_s = 1'b1;
      gnt_id_s    = ~last_r;
    end else if (req0) begin
      gnt_valid_s = 1'b1;
      gnt_id_s    = 1'b0;
    end else if (req1) begin
      gnt_valid_s = 1'b1;
      gnt_id_s    = 1'b1;
    end else begin
      gnt_valid_s = 1'b0;
      gnt_id_s    = 1'b0;
    end

    case (state_r)
      IDLE: begin
        busy_nxt_s = 1'b0;
        if (gnt_valid_s) begin
          sel_we_s    = gnt_id_s ? we1 : we0;
          state_nxt_s = ACCESS;
          gnt_nxt_s   = gnt_id_s;
          we_nxt_s    = sel_we_s;
          addr_nxt_s  = gnt_id_s ? addr1 : addr0;
          wdata_nxt_s = gnt_id_s ? wdata1 : wdata0;
          cnt_nxt_s   = sel_we_s ? 3'd0 : LAT_CNT;
          write_nxt_s = sel_we_s;
          busy_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCESS: begin
        busy_nxt_s = 1'b1;
        if (we_r) begin
          state_nxt_s = DONE;
          ack0_nxt_s  = ~gnt_r;
          ack1_nxt_s  = gnt_r;
        end else if (cnt_r == 3'd0) begin
          state_nxt_s = DONE;
          rdata_nxt_s = mem_dout;
          ack0_nxt_s  = ~gnt_r;
          ack1_nxt_s  = gnt_r;
        end else begin
          cnt_nxt_s = cnt_r - 3'd1;
        end
      end
      DONE: begin
        busy_nxt_s  = 1'b0;
        last_nxt_s  = gnt_r;
        state_nxt_s = IDLE;
      end
      default: begin
        busy_nxt_s  = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 3'd0;
      last_r  <= 1'b1;
      gnt_r   <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= 8'd0;
      wdata_r <= 32'd0;
      write_r <= 1'b0;
      ack0_r  <= 1'b0;
      ack1_r  <= 1'b0;
      busy_r  <= 1'b0;
      rdata_r <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      last_r  <= last_nxt_s;
      gnt_r   <= gnt_nxt_s;
      we_r    <= we_nxt_s;
      addr_r  <= addr_nxt_s;
      wdata_r <= wdata_nxt_s;
      write_r <= write_nxt_s;
      ack0_r  <= ack0_nxt_s;
      ack1_r  <= ack1_nxt_s;
      busy_r  <= busy_nxt_s;
      rdata_r <= rdata_nxt_s;
    end
  end

  assign ack0      = ack0_r;
  assign ack1      = ack1_r;
  assign rdata     = rdata_r;
  assign busy      = busy_r;
  assign mem_addr  = addr_r;
  assign mem_write = write_r;
  assign mem_in    = wdata_r;

  mem_arbiter_checker u_checker (
    .clk       (clk),
    .rst_n     (rst_n),
    .ack0      (ack0_r),
    .ack1      (ack1_r),
    .busy      (busy_r),
    .mem_write (write_r)
  );

endmodule

// Protocol invariants: acks are mutually exclusive, writes only happen while busy.
module mem_arbiter_checker (
  input logic clk,
  input logic rst_n,
  input logic ack0,
  input logic ack1,
  input logic busy,
  input logic mem_write
);

  ack_onehot_a: assert property (@(posedge clk) disable iff (!rst_n) !(ack0 && ack1));
  write_busy_a: assert property (@(posedge clk) disable iff (!rst_n) mem_write |-> busy);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: four arbiter instances (RD_LAT 0,1,3,7) each with a latency-aware memory model.
module tb_mem_arbiter;

  localparam int LAT_TAB [4] = '{0, 1, 3, 7};

  typedef struct packed {
    logic [1:0]  k;
    logic        id;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_v [4];
  logic        req1_v [4];
  logic        we0_v [4];
  logic        we1_v [4];
  logic [7:0]  addr0_v [4];
  logic [7:0]  addr1_v [4];
  logic [31:0] wdata0_v [4];
  logic [31:0] wdata1_v [4];
  logic        ack0_v [4];
  logic        ack1_v [4];
  logic [31:0] rdata_v [4];
  logic        busy_v [4];
  logic [7:0]  mem_addr_v [4];
  logic        mem_write_v [4];
  logic [31:0] mem_in_v [4];
  logic [31:0] mem_dout_v [4];

  logic [31:0] mem_m [4][256];
  logic [31:0] shadow [4][256];
  int          age_v [4];

  txn_t ack_q [$];
  txn_t wr_q [$];
  txn_t mon_t;
  txn_t mon_w;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mem_arbiter #(.RD_LAT(LAT_TAB[g])) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0      (req0_v[g]),
      .req1      (req1_v[g]),
      .we0       (we0_v[g]),
      .we1       (we1_v[g]),
      .addr0     (addr0_v[g]),
      .addr1     (addr1_v[g]),
      .wdata0    (wdata0_v[g]),
      .wdata1    (wdata1_v[g]),
      .ack0      (ack0_v[g]),
      .ack1      (ack1_v[g]),
      .rdata     (rdata_v[g]),
      .busy      (busy_v[g]),
      .mem_addr  (mem_addr_v[g]),
      .mem_write (mem_write_v[g]),
      .mem_in    (mem_in_v[g]),
      .mem_dout  (mem_dout_v[g])
    );
  end

  // Memory model: data is only valid once the access has been open for RD_LAT cycles.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (mem_write_v[k]) mem_m[k][mem_addr_v[k]] <= mem_in_v[k];
      age_v[k] <= busy_v[k] ? age_v[k] + 1 : 0;
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      mem_dout_v[k] = (age_v[k] >= LAT_TAB[k]) ? mem_m[k][mem_addr_v[k]] : 32'hBAD0_BAD0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Monitor: every ack and every memory write is matched against the scoreboard.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (ack0_v[k] && ack1_v[k]) check_eq("ack_both", 32'd1, 32'd0);
      if (ack0_v[k] || ack1_v[k]) begin
        if (ack_q.size() == 0) begin
          check_eq("ack_spurious", 32'd1, 32'd0);
        end else begin
          mon_t = ack_q.pop_front();
          check_eq("ack_inst", k, {30'd0, mon_t.k});
          check_eq("ack_id", {31'd0, ack1_v[k]}, {31'd0, mon_t.id});
          if (!mon_t.we) check_eq("rdata", rdata_v[k], mon_t.data);
        end
      end
      if (mem_write_v[k]) begin
        if (wr_q.size() == 0) begin
          check_eq("write_spurious", 32'd1, 32'd0);
        end else begin
          mon_w = wr_q.pop_front();
          check_eq("wr_inst", k, {30'd0, mon_w.k});
          check_eq("wr_addr", {24'd0, mem_addr_v[k]}, {24'd0, mon_w.addr});
          check_eq("wr_data", mem_in_v[k], mon_w.data);
        end
      end
    end
  end

  task automatic drive(input int k, input logic id, input logic req, input logic we,
                       input logic [7:0] addr, input logic [31:0] data);
    if (id) begin
      req1_v[k] = req; we1_v[k] = we; addr1_v[k] = addr; wdata1_v[k] = data;
    end else begin
      req0_v[k] = req; we0_v[k] = we; addr0_v[k] = addr; wdata0_v[k] = data;
    end
  endtask

  task automatic expect_txn(input int k, input logic id, input logic we,
                            input logic [7:0] addr, input logic [31:0] data);
    txn_t t;
    t.k = k[1:0]; t.id = id; t.we = we; t.addr = addr;
    t.data = we ? data : shadow[k][addr];
    if (we) begin
      shadow[k][addr] = data;
      wr_q.push_back(t);
    end
    ack_q.push_back(t);
  endtask

  // Single access on an idle instance; called at a negedge, returns at a negedge in IDLE.
  task automatic do_access(input int k, input logic id, input logic we,
                           input logic [7:0] addr, input logic [31:0] data);
    int n = 0;
    logic seen = 1'b0;
    logic ack_s;
    expect_txn(k, id, we, addr, data);
    drive(k, id, 1'b1, we, addr, data);
    @(posedge clk);
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) drive(k, id, 1'b1, ~we, ~addr, ~data);
      ack_s = id ? ack1_v[k] : ack0_v[k];
      if (ack_s) begin
        seen = 1'b1;
        check_eq(we ? "lat_wr" : "lat_rd", n, we ? 32'd2 : LAT_TAB[k] + 2);
        drive(k, id, 1'b0, 1'b0, 8'd0, 32'd0);
      end
    end
    if (!seen) begin
      check_eq("ack_timeout", 32'd0, 32'd1);
      drive(k, id, 1'b0, 1'b0, 8'd0, 32'd0);
    end
    @(negedge clk);
  endtask

  // Both requesters write together as reset is released; grants must start with requester 0.
  task automatic both_run(input int k, input int n_acks, input logic drop_on_ack,
                          input logic [31:0] d0, input logic [31:0] d1);
    int got = 0;
    int cyc = 0;
    for (int i = 0; i < n_acks; i++) begin
      if (i % 2 == 0) expect_txn(k, 1'b0, 1'b1, 8'h20, d0);
      else            expect_txn(k, 1'b1, 1'b1, 8'h21, d1);
    end
    drive(k, 1'b0, 1'b1, 1'b1, 8'h20, d0);
    drive(k, 1'b1, 1'b1, 1'b1, 8'h21, d1);
    rst_n = 1'b1;
    while (got < n_acks && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (ack0_v[k]) begin
        got++;
        if (drop_on_ack) req0_v[k] = 1'b0;
      end
      if (ack1_v[k]) begin
        got++;
        if (drop_on_ack) req1_v[k] = 1'b0;
      end
    end
    if (got < n_acks) check_eq("both_timeout", got, n_acks);
    drive(k, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
    drive(k, 1'b1, 1'b0, 1'b0, 8'd0, 32'd0);
    @(negedge clk);
  endtask

  logic [7:0] bank_addr [8];

  initial begin
    bank_addr = '{8'h00, 8'h3F, 8'h40, 8'h7F, 8'h80, 8'hBF, 8'hC0, 8'hFF};
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(k, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
      drive(k, 1'b1, 1'b0, 1'b0, 8'd0, 32'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ack0", {31'd0, ack0_v[0]}, 32'd0);
    check_eq("rst_ack1", {31'd0, ack1_v[0]}, 32'd0);
    check_eq("rst_busy", {31'd0, busy_v[0]}, 32'd0);
    check_eq("rst_mem_write", {31'd0, mem_write_v[0]}, 32'd0);
    check_eq("rst_mem_addr", {24'd0, mem_addr_v[0]}, 32'd0);
    check_eq("rst_mem_in", mem_in_v[0], 32'd0);
    check_eq("rst_rdata", rdata_v[0], 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write then read back on every latency variant.
    for (int k = 0; k < 4; k++) begin
      do_access(k, 1'b0, 1'b1, 8'h45, 32'hDEAD_BEEF);
      do_access(k, 1'b1, 1'b0, 8'h45, 32'd0);
    end

    // Bank boundaries on the RD_LAT=1 instance.
    for (int i = 0; i < 8; i++)
      do_access(1, i[0], 1'b1, bank_addr[i], 32'hB00C_0000 | (i << 8) | {24'd0, bank_addr[i]});
    for (int i = 0; i < 8; i++)
      do_access(1, ~i[0], 1'b0, bank_addr[i], 32'd0);

    // Tie out of reset, both held: grants 0,1,0,1.
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    both_run(1, 4, 1'b0, 32'hA5A5_0001, 32'h5A5A_0002);

    // Reset in the second ACCESS cycle of an RD_LAT=3 read.
    drive(2, 1'b1, 1'b1, 1'b0, 8'h45, 32'd0);
    @(posedge clk);
    @(negedge clk);
    drive(2, 1'b1, 1'b0, 1'b0, 8'h00, 32'd0);
    @(negedge clk);
    check_eq("mid_busy", {31'd0, busy_v[2]}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_write", {31'd0, mem_write_v[2]}, 32'd0);
    check_eq("mid_rst_busy", {31'd0, busy_v[2]}, 32'd0);
    check_eq("mid_rst_rdata", rdata_v[2], 32'd0);
    check_eq("mid_rst_ack", {30'd0, ack0_v[2], ack1_v[2]}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    both_run(2, 2, 1'b1, 32'h0000_C0DE, 32'h0000_F00D);

    repeat (3) @(negedge clk);
    check_eq("ack_q_empty", ack_q.size(), 32'd0);
    check_eq("wr_q_empty", wr_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
